// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd operand sequencer.
package fpadd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESULT,
        OUT
    } seq_state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam int unsigned EXP_MSB = 30;
    localparam int unsigned EXP_LSB = 23;

    function automatic logic exp_is_zero(input logic [31:0] f);
        return f[EXP_MSB:EXP_LSB] == '0;
    endfunction

endpackage

// File: rtl/fpadd_seq_if.sv
// Operand/result streams plus the fpadd core handshake of the sequencer.
interface fpadd_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_err;
    logic        fp_start;
    logic [31:0] fp_a;
    logic [31:0] fp_b;
    logic [31:0] fp_sum;
    logic        fp_done;

    modport slave (
        input  in_valid, in_a, in_b, in_acc, in_last, out_ready, fp_sum, fp_done,
        output in_ready, out_valid, out_sum, out_err, fp_start, fp_a, fp_b
    );

    modport master (
        output in_valid, in_a, in_b, in_acc, in_last, out_ready, fp_sum, fp_done,
        input  in_ready, out_valid, out_sum, out_err, fp_start, fp_a, fp_b
    );
endinterface

// File: rtl/fpadd_seq_bypass.sv
// Zero/denormal operand detect and local result select; fpadd cannot see
// exponent-0 operands correctly because it always prepends the hidden bit.
module fpadd_seq_bypass
    import fpadd_pkg::*;
(
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    input  logic        i_acc_first,
    output logic        o_bypass,
    output logic [31:0] o_res
);

    logic w_a_zero;
    logic w_b_zero;

    assign w_a_zero = exp_is_zero(i_opa);
    assign w_b_zero = exp_is_zero(i_opb);

    always_comb begin
        o_bypass = i_acc_first | w_a_zero | w_b_zero;
        // The first beat of an accumulation passes in_b through untouched.
        if (i_acc_first) begin
            o_res = i_opb;
        end else if (w_a_zero && w_b_zero) begin
            o_res = FP_ZERO;
        end else if (w_a_zero) begin
            o_res = i_opb;
        end else begin
            o_res = i_opa;
        end
    end

endmodule

// File: rtl/fpadd_seq.sv
// Operand sequencer around the fpadd core with running accumulation.
// Define FPADD_SEQ_TIMEOUT_EN to add the WAIT timeout (qNaN + out_err).
module fpadd_seq
    import fpadd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 511,
    parameter int unsigned CTR_W       = 9
) (
    input  logic        clk,
    input  logic        reset,
    fpadd_seq_if.slave  bus
);

    if ((1 << CTR_W) <= TIMEOUT_CYC) begin : g_ctr_too_narrow
        $error("CTR_W too narrow for TIMEOUT_CYC");
    end

    seq_state_t  r_state, w_state_nxt;
    logic        r_in_ready;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_out_sum, w_out_sum_nxt;
    logic        r_out_err, w_out_err_nxt;
    logic        r_fp_start, w_fp_start_nxt;
    logic [31:0] r_fp_a, w_fp_a_nxt;
    logic [31:0] r_fp_b, w_fp_b_nxt;
    logic [31:0] r_acc, w_acc_nxt;
    logic        r_acc_empty, w_acc_empty_nxt;
    logic [31:0] r_res, w_res_nxt;
    logic        r_err, w_err_nxt;
    logic        r_beat_acc, w_beat_acc_nxt;
    logic        r_beat_last, w_beat_last_nxt;

    logic        w_accept;
    logic [31:0] w_opa;
    logic        w_bypass;
    logic [31:0] w_bypass_res;
    logic        w_timeout;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_opa    = bus.in_acc ? r_acc : bus.in_a;

    fpadd_seq_bypass u_bypass (
        .i_opa       (w_opa),
        .i_opb       (bus.in_b),
        .i_acc_first (bus.in_acc & r_acc_empty),
        .o_bypass    (w_bypass),
        .o_res       (w_bypass_res)
    );

`ifdef FPADD_SEQ_TIMEOUT_EN
    logic [CTR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state != WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the number of WAIT cycles already completed.
    assign w_timeout = (r_state == WAIT) && (r_cnt == CTR_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_err_nxt   = r_out_err;
        w_fp_start_nxt  = 1'b0;
        w_fp_a_nxt      = r_fp_a;
        w_fp_b_nxt      = r_fp_b;
        w_acc_nxt       = r_acc;
        w_acc_empty_nxt = r_acc_empty;
        w_res_nxt       = r_res;
        w_err_nxt       = r_err;
        w_beat_acc_nxt  = r_beat_acc;
        w_beat_last_nxt = r_beat_last;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_beat_acc_nxt  = bus.in_acc;
                    w_beat_last_nxt = bus.in_last;
                    w_err_nxt       = 1'b0;
                    if (w_bypass) begin
                        w_res_nxt   = w_bypass_res;
                        w_state_nxt = RESULT;
                    end else begin
                        w_fp_a_nxt     = w_opa;
                        w_fp_b_nxt     = bus.in_b;
                        w_fp_start_nxt = 1'b1;
                        w_state_nxt    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.fp_done) begin
                    w_res_nxt   = bus.fp_sum;
                    w_state_nxt = RESULT;
                end else if (w_timeout) begin
                    w_res_nxt   = FP_QNAN;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (r_beat_acc) begin
                    w_acc_nxt       = r_res;
                    w_acc_empty_nxt = 1'b0;
                end
                if (!r_beat_acc || r_beat_last) begin
                    w_out_sum_nxt   = r_res;
                    w_out_err_nxt   = r_err;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = OUT;
                    if (r_beat_acc) begin
                        w_acc_nxt       = FP_ZERO;
                        w_acc_empty_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_err   <= 1'b0;
            r_fp_start  <= 1'b0;
            r_fp_a      <= '0;
            r_fp_b      <= '0;
            r_acc       <= '0;
            r_acc_empty <= 1'b1;
            r_res       <= '0;
            r_err       <= 1'b0;
            r_beat_acc  <= 1'b0;
            r_beat_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_err   <= w_out_err_nxt;
            r_fp_start  <= w_fp_start_nxt;
            r_fp_a      <= w_fp_a_nxt;
            r_fp_b      <= w_fp_b_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_empty <= w_acc_empty_nxt;
            r_res       <= w_res_nxt;
            r_err       <= w_err_nxt;
            r_beat_acc  <= w_beat_acc_nxt;
            r_beat_last <= w_beat_last_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_err   = r_out_err;
    assign bus.fp_start  = r_fp_start;
    assign bus.fp_a      = r_fp_a;
    assign bus.fp_b      = r_fp_b;

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq with a table-driven fpadd stub whose done
// stays high until the next start pulse.
module tb_fpadd_seq;

    localparam logic [31:0] F1   = 32'h3F80_0000;
    localparam logic [31:0] F2   = 32'h4000_0000;
    localparam logic [31:0] F3   = 32'h4040_0000;
    localparam logic [31:0] F4   = 32'h4080_0000;
    localparam logic [31:0] F5   = 32'h40A0_0000;
    localparam logic [31:0] FM1  = 32'hBF80_0000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   start_cnt;
    int   ov_cnt;
    int   stub_lat;
    bit   stub_hang;
    logic        st_busy;
    int          st_cnt;
    logic [31:0] st_sum;

    fpadd_seq_if bus();

    fpadd_seq #(.TIMEOUT_CYC(511), .CTR_W(9)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {F1, F2}:  return F3;
            {F1, F1}:  return F2;
            {F2, F1}:  return F3;
            {F3, F1}:  return F4;
            {F3, FM1}: return F2;
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_busy     <= 1'b0;
            st_cnt      <= 0;
            st_sum      <= '0;
            bus.fp_done <= 1'b0;
            bus.fp_sum  <= '0;
        end else if (bus.fp_start) begin
            st_busy     <= 1'b1;
            st_cnt      <= stub_lat;
            st_sum      <= ref_sum(bus.fp_a, bus.fp_b);
            bus.fp_done <= 1'b0;
        end else if (st_busy && !stub_hang) begin
            if (st_cnt == 0) begin
                bus.fp_done <= 1'b1;
                bus.fp_sum  <= st_sum;
                st_busy     <= 1'b0;
            end else begin
                st_cnt <= st_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (rst_n && bus.fp_start) start_cnt++;
    always @(posedge bus.out_valid) ov_cnt++;

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic acc, input logic last);
        int n;
        n = 0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_acc = acc;
        bus.in_last = last;
        bus.in_valid = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!bus.in_ready && n < 1000);
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_accept: in_ready never rose within %0d cycles", n);
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] sum, output logic err, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.out_valid && cyc < 2000);
        if (!bus.out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_out: out_valid not seen within %0d cycles", cyc);
        end
        sum = bus.out_sum;
        err = bus.out_err;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_sum !== 32'h0) begin n_fail++; $display("FAIL reset_out_sum got %h want 0", bus.out_sum); end
        n_tests++; if (bus.fp_start !== 1'b0 || bus.fp_a !== 32'h0 || bus.fp_b !== 32'h0) begin
            n_fail++; $display("FAIL reset_fp got start=%b a=%h b=%h want 0/0/0", bus.fp_start, bus.fp_a, bus.fp_b);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic_add();
        logic [31:0] s;
        logic e;
        int c, s0;
        s0 = start_cnt;
        send(F1, F2, 1'b0, 1'b0);
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_drop got %b want 0", bus.in_ready); end
        wait_out(s, e, c);
        n_tests++; if (s !== F3) begin n_fail++; $display("FAIL basic_sum got %h want %h", s, F3); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", e); end
        n_tests++; if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL basic_starts got %0d want 1", start_cnt - s0); end
        release_out();
    endtask

    task automatic test_accumulate();
        logic [31:0] s;
        logic e;
        int c, s0, o0;
        s0 = start_cnt;
        o0 = ov_cnt;
        for (int i = 0; i < 4; i++) send(32'h1234_5678, F1, 1'b1, i == 3);
        wait_out(s, e, c);
        n_tests++; if (s !== F4) begin n_fail++; $display("FAIL acc_sum got %h want %h", s, F4); end
        n_tests++; if (start_cnt - s0 != 3) begin n_fail++; $display("FAIL acc_starts got %0d want 3", start_cnt - s0); end
        n_tests++; if (ov_cnt - o0 != 1) begin n_fail++; $display("FAIL acc_out_count got %0d want 1", ov_cnt - o0); end
        release_out();
        // A fresh single-beat accumulation proves the accumulator was emptied.
        s0 = start_cnt;
        send(32'h0, F5, 1'b1, 1'b1);
        wait_out(s, e, c);
        n_tests++; if (s !== F5) begin n_fail++; $display("FAIL acc_single_sum got %h want %h", s, F5); end
        n_tests++; if (start_cnt != s0) begin n_fail++; $display("FAIL acc_single_starts got %0d want 0", start_cnt - s0); end
        release_out();
    endtask

    task automatic test_bypass();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] te [3];
        int s0;
        ta = '{32'h0000_0000, F5,           32'h8000_0000};
        tb = '{F5,            32'h0000_0001, 32'h0000_0005};
        te = '{F5,            F5,           32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            s0 = start_cnt;
            send(ta[i], tb[i], 1'b0, 1'b0);
            n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass%0d_early got %b want 0", i, bus.out_valid); end
            @(posedge clk);
            #1;
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass%0d_latency got %b want 1", i, bus.out_valid); end
            n_tests++; if (bus.out_sum !== te[i]) begin n_fail++; $display("FAIL bypass%0d_sum got %h want %h", i, bus.out_sum, te[i]); end
            n_tests++; if (start_cnt != s0) begin n_fail++; $display("FAIL bypass%0d_starts got %0d want 0", i, start_cnt - s0); end
            release_out();
        end
    endtask

    task automatic test_interleave();
        logic [31:0] s;
        logic e;
        int c, s0;
        s0 = start_cnt;
        send(32'h0, F1, 1'b1, 1'b0);
        send(F1, F2, 1'b0, 1'b0);
        wait_out(s, e, c);
        n_tests++; if (s !== F3) begin n_fail++; $display("FAIL inter_indep_sum got %h want %h", s, F3); end
        release_out();
        send(32'h0, F1, 1'b1, 1'b1);
        wait_out(s, e, c);
        n_tests++; if (s !== F2) begin n_fail++; $display("FAIL inter_acc_sum got %h want %h", s, F2); end
        n_tests++; if (start_cnt - s0 != 2) begin n_fail++; $display("FAIL inter_starts got %0d want 2", start_cnt - s0); end
        release_out();
    endtask

    task automatic test_back_pressure();
        logic [31:0] s;
        logic e;
        int c, bad;
        send(F1, F2, 1'b0, 1'b0);
        wait_out(s, e, c);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== F3 || bus.in_ready !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        release_out();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] s;
        logic e;
        int c;
        stub_lat = 50;
        send(F1, F2, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.fp_a !== 32'h0 || bus.fp_b !== 32'h0) begin
            n_fail++; $display("FAIL midrst_fp got a=%h b=%h want 0/0", bus.fp_a, bus.fp_b);
        end
        n_tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ctrl got ready=%b valid=%b err=%b want 0/0/0", bus.in_ready, bus.out_valid, bus.out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stub_lat = 4;
        @(posedge clk);
        #1;
        send(F3, FM1, 1'b0, 1'b0);
        wait_out(s, e, c);
        n_tests++; if (s !== F2) begin n_fail++; $display("FAIL midrst_next_sum got %h want %h", s, F2); end
        release_out();
    endtask

`ifdef FPADD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] s;
        logic e;
        int c;
        stub_hang = 1'b1;
        send(F1, F2, 1'b0, 1'b0);
        wait_out(s, e, c);
        n_tests++; if (s !== 32'h7FC0_0000) begin n_fail++; $display("FAIL timeout_sum got %h want 7fc00000", s); end
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", e); end
        n_tests++; if (c != 513) begin n_fail++; $display("FAIL timeout_latency got %0d want 513", c); end
        release_out();
        stub_hang = 1'b0;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail = 0;
        start_cnt = 0;
        ov_cnt = 0;
        stub_lat = 4;
        stub_hang = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_acc = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_accumulate();
        test_bypass();
        test_interleave();
        test_back_pressure();
        test_reset_midop();
`ifdef FPADD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
